// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a shared BCD-to-7-segment decoder.
//
// The controller holds a NUM_DIGITS-digit BCD display word. It drives one digit at a
// time onto bcd_out and sets the matching bit of the one-hot digit_en. Each digit is
// preceded by a BLANK gap (digit_en all-zero, bcd_out already showing the upcoming
// digit) and is then shown for REFRESH_DIV cycles. New words arrive through a
// valid/ready handshake into a pending register. A pending word is copied into the
// display register only at a frame boundary, or at once while idle.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - leading zero digits (never digit 0) output 4'hF.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   scan enable; low forces IDLE
//   load_valid  in   load_data valid
//   load_ready  out  a new word can be accepted
//   load_data   in   4*NUM_DIGITS BCD digits, digit 0 in bits [3:0]
//   bcd_out     out  BCD code to the shared decoder (4'hF = blank)
//   digit_en    out  one-hot active-high digit enable
//   frame_done  out  one-cycle pulse during the final SHOW cycle of a frame

module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW    = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0] SHOW_LAST  = DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_LAST =
        DIV_WIDTH'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  load_ready_q, load_ready_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  frame_done_q, frame_done_d;

    logic                  frame_end;
    logic                  xfer;
    logic                  commit;
    logic [3:0]            sel_digit;
    logic                  suppress;

    // ------------------------------------------------------------------
    // Scan sequencing: state, digit index and dwell/blank counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                        cnt_d   = '0;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load handshake and frame-boundary commit
    // ------------------------------------------------------------------
    // load_ready_q always mirrors an empty pending register, so a transfer
    // and a commit can never coincide: a transfer on the commit edge can only
    // happen when nothing was pending, and then waits for the next frame end.
    always_comb begin
        frame_end = (state_q == ST_SHOW) && (idx_q == LAST_IDX) && (cnt_q == SHOW_LAST);
        xfer      = load_valid && load_ready_q;
        commit    = pend_full_q && (frame_end || (state_q == ST_IDLE));

        pend_d       = xfer ? load_data : pend_q;
        pend_full_d  = xfer || (pend_full_q && !commit);
        disp_d       = commit ? pend_q : disp_q;
        load_ready_d = !pend_full_d;
    end

    // ------------------------------------------------------------------
    // Digit select and optional leading-zero suppression
    // ------------------------------------------------------------------
    // Outputs are decoded from the next state and next display word, so the
    // registered outputs line up with the registered state and a freshly
    // committed word is visible from the first BLANK cycle of the new frame.
    always_comb begin
        sel_digit = 4'h0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_digit = disp_d[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // Walk from the most significant digit down; a digit is a leading zero
    // while it and every digit above it are zero. Digit 0 is never flagged.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            zero_run = zero_run && (disp_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lead_zero[NUM_DIGITS-1-k] = zero_run;
        end
        suppress = lead_zero[idx_d];
    end
`else
    always_comb begin
        suppress = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bcd_d        = 4'hF;
        digit_en_d   = '0;
        frame_done_d = 1'b0;

        unique case (state_d)
            ST_BLANK: begin
                bcd_d = suppress ? 4'hF : sel_digit;
            end
            ST_SHOW: begin
                bcd_d        = suppress ? 4'hF : sel_digit;
                digit_en_d   = NUM_DIGITS'(1) << idx_d;
                frame_done_d = (idx_d == LAST_IDX) && (cnt_d == SHOW_LAST);
            end
            default: begin
                bcd_d = 4'hF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            bcd_q        <= 4'hF;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            bcd_q        <= bcd_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign bcd_out    = bcd_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
